// File: rtl/pool_frame_sequencer.sv
// ---------------------------------------------------------------------------
// pool_frame_sequencer
//
// Purpose:
//   Frame sequencer in front of the max-pool stage. Buffers one
//   channel-interleaved pixel from an unframed valid/ready stream and
//   re-emits it as a contiguous CHANNEL_NUM-beat burst followed by at least
//   GAP_CYCLES idle cycles, adding sop/eop/sof/eof line and frame framing.
//
// Configuration macro:
//   POOL_SEQ_STATS_EN - when defined, frame_cnt_o counts completed frames
//                       (16 bit, wraps). When undefined, frame_cnt_o is 0.
//
// Ports:
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   start_i       in   arm one frame (pulse)
//   s_valid_i     in   upstream sample valid
//   s_data_i      in   upstream sample (signed)
//   s_ready_o     out  upstream transfer allowed
//   m_valid_o     out  sample valid to pool stage
//   m_data_o      out  sample to pool stage
//   m_sop_o       out  first beat of a line
//   m_eop_o       out  last beat of a line
//   m_sof_o       out  first beat of frame
//   m_eof_o       out  last beat of frame
//   busy_o        out  sequencer not idle
//   frame_done_o  out  1-cycle pulse, cycle after m_eof_o
//   err_o         out  sticky: start_i seen while busy
//   frame_cnt_o   out  completed frame count
// ---------------------------------------------------------------------------
module pool_frame_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 3,
    parameter int STRING_LEN  = 4,
    parameter int LINE_NUM    = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start_i,
    input  logic                         s_valid_i,
    input  logic signed [DATA_WIDTH-1:0] s_data_i,
    output logic                         s_ready_o,
    output logic                         m_valid_o,
    output logic signed [DATA_WIDTH-1:0] m_data_o,
    output logic                         m_sop_o,
    output logic                         m_eop_o,
    output logic                         m_sof_o,
    output logic                         m_eof_o,
    output logic                         busy_o,
    output logic                         frame_done_o,
    output logic                         err_o,
    output logic [15:0]                  frame_cnt_o
);

    localparam int CW = $clog2(CHANNEL_NUM + 1);
    localparam int XW = $clog2(STRING_LEN + 1);
    localparam int YW = $clog2(LINE_NUM + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [CW-1:0] C_LAST   = CW'(CHANNEL_NUM - 1);
    localparam logic [XW-1:0] COL_LAST = XW'(STRING_LEN - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(LINE_NUM - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t r_state, w_state_d;

    logic [CW-1:0] r_chan, w_chan_d;
    logic [XW-1:0] r_col,  w_col_d;
    logic [YW-1:0] r_row,  w_row_d;
    logic [GW-1:0] r_gap,  w_gap_d;

    logic signed [DATA_WIDTH-1:0] r_buf [CHANNEL_NUM];

    logic                         r_ready;
    logic                         r_valid;
    logic signed [DATA_WIDTH-1:0] r_data;
    logic                         r_sop, r_eop, r_sof, r_eof;
    logic                         r_busy, r_done, r_err;

    logic w_accept;
    logic w_last_beat;
    logic w_emit_d;

    assign w_accept    = s_valid_i & r_ready;
    assign w_last_beat = (r_state == S_EMIT) && (r_chan == C_LAST) &&
                         (r_col == COL_LAST) && (r_row == ROW_LAST);
    assign w_emit_d    = (w_state_d == S_EMIT);

    // Next-state and counter logic
    always_comb begin
        w_state_d = r_state;
        w_chan_d  = r_chan;
        w_col_d   = r_col;
        w_row_d   = r_row;
        w_gap_d   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_d = S_LOAD;
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (r_chan == C_LAST) begin
                        w_chan_d  = '0;
                        w_state_d = S_EMIT;
                    end else begin
                        w_chan_d = r_chan + 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (r_chan == C_LAST) begin
                    w_chan_d  = '0;
                    w_state_d = S_GAP;
                    if (r_col == COL_LAST) begin
                        w_col_d = '0;
                        w_row_d = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                    end else begin
                        w_col_d = r_col + 1'b1;
                    end
                end else begin
                    w_chan_d = r_chan + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_gap_d = '0;
                    // Both position counters back at zero inside GAP can only
                    // mean the last pixel of the frame was just emitted.
                    w_state_d = (r_col == '0 && r_row == '0) ? S_DONE : S_LOAD;
                end else begin
                    w_gap_d = r_gap + 1'b1;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_chan  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_d;
            r_chan  <= w_chan_d;
            r_col   <= w_col_d;
            r_row   <= w_row_d;
            r_gap   <= w_gap_d;
        end
    end

    // Pixel buffer, contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_accept) r_buf[r_chan] <= s_data_i;
    end

    // Registered outputs are computed from next-state values so that each
    // output beat lines up with the cycle the FSM spends in that beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= (r_state == S_LOAD) && !(w_accept && r_chan == C_LAST);
            r_valid <= w_emit_d;
            if (w_emit_d) begin
                // Bypass covers CHANNEL_NUM=1, where beat 0 is the sample
                // being written into the buffer on this same edge.
                r_data <= (w_accept && r_chan == w_chan_d) ? s_data_i : r_buf[w_chan_d];
            end
            r_sop  <= w_emit_d && (w_chan_d == '0) && (w_col_d == '0);
            r_eop  <= w_emit_d && (w_chan_d == C_LAST) && (w_col_d == COL_LAST);
            r_sof  <= w_emit_d && (w_chan_d == '0) && (w_col_d == '0) && (w_row_d == '0);
            r_eof  <= w_emit_d && (w_chan_d == C_LAST) && (w_col_d == COL_LAST) &&
                      (w_row_d == ROW_LAST);
            r_busy <= (w_state_d != S_IDLE);
            r_done <= w_last_beat;
            r_err  <= r_err | (start_i & (r_state != S_IDLE));
        end
    end

`ifdef POOL_SEQ_STATS_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
        end else if (r_state == S_DONE) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt_o = r_frame_cnt;
`else
    assign frame_cnt_o = '0;
`endif

    assign s_ready_o    = r_ready;
    assign m_valid_o    = r_valid;
    assign m_data_o     = r_data;
    assign m_sop_o      = r_sop;
    assign m_eop_o      = r_eop;
    assign m_sof_o      = r_sof;
    assign m_eof_o      = r_eof;
    assign busy_o       = r_busy;
    assign frame_done_o = r_done;
    assign err_o        = r_err;

endmodule

// File: tb/tb_pool_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pool_frame_sequencer
//
// Scoreboard bench for pool_frame_sequencer. Instance dut uses
// CHANNEL_NUM=3, STRING_LEN=4, LINE_NUM=4, GAP_CYCLES=1; instance dut_g3
// uses GAP_CYCLES=3 and is only used to measure burst spacing.
// Expected frame count depends on POOL_SEQ_STATS_EN.
// ---------------------------------------------------------------------------
module tb_pool_frame_sequencer;

    localparam int FRAME_BEATS = 48;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              s_valid;
    logic signed [7:0] s_data;
    logic              s_ready_o, m_valid_o, m_sop_o, m_eop_o, m_sof_o, m_eof_o;
    logic signed [7:0] m_data_o;
    logic              busy_o, frame_done_o, err_o;
    logic [15:0]       frame_cnt_o;

    logic              start_b;
    logic              valid_b;
    logic signed [7:0] data_b;
    logic              ready_b, mvalid_b, sop_b, eop_b, sof_b, eof_b;
    logic signed [7:0] mdata_b;
    logic              busy_b, done_b, err_b;
    logic [15:0]       fcnt_b;

    always #5 clk = ~clk;

    pool_frame_sequencer #(
        .DATA_WIDTH(8), .CHANNEL_NUM(3), .STRING_LEN(4), .LINE_NUM(4), .GAP_CYCLES(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready_o),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o),
        .m_sop_o(m_sop_o), .m_eop_o(m_eop_o), .m_sof_o(m_sof_o), .m_eof_o(m_eof_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o),
        .frame_cnt_o(frame_cnt_o)
    );

    pool_frame_sequencer #(
        .DATA_WIDTH(8), .CHANNEL_NUM(3), .STRING_LEN(4), .LINE_NUM(4), .GAP_CYCLES(3)
    ) dut_g3 (
        .clk(clk), .reset_n(reset_n), .start_i(start_b),
        .s_valid_i(valid_b), .s_data_i(data_b), .s_ready_o(ready_b),
        .m_valid_o(mvalid_b), .m_data_o(mdata_b),
        .m_sop_o(sop_b), .m_eop_o(eop_b), .m_sof_o(sof_b), .m_eof_o(eof_b),
        .busy_o(busy_b), .frame_done_o(done_b), .err_o(err_b),
        .frame_cnt_o(fcnt_b)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       sof;
        logic       eof;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

`ifdef POOL_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Framing derived from the beat's position within a 3x4x4 frame
    function automatic exp_t model(input int n);
        exp_t e;
        int   p, ch, col, row;
        p   = n / 3;
        ch  = n % 3;
        col = p % 4;
        row = p / 4;
        e.data = 8'(n);
        e.sop  = (ch == 0) && (col == 0);
        e.eop  = (ch == 2) && (col == 3);
        e.sof  = e.sop && (row == 0);
        e.eof  = e.eop && (row == 3);
        return e;
    endfunction

    // ---------------- monitor for dut ----------------
    int   run_len    = 0;
    int   beats_seen = 0;
    int   done_seen  = 0;
    logic eof_prev   = 1'b0;

    always @(posedge clk) begin
        #2;
        if (!reset_n) begin
            run_len  = 0;
            eof_prev = 1'b0;
        end else begin
            check("frame_done_timing", 64'(frame_done_o), 64'(eof_prev));
            if (frame_done_o) done_seen++;
            if (m_valid_o) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_data_flags",
                          64'({m_data_o, m_sop_o, m_eop_o, m_sof_o, m_eof_o}), 64'(e));
                end
                beats_seen++;
                run_len++;
            end else begin
                if (run_len != 0) check("burst_len", 64'(run_len), 64'd3);
                run_len = 0;
            end
            eof_prev = m_valid_o & m_eof_o;
        end
    end

    // ---------------- monitor for dut_g3 ----------------
    int   idle_b     = 0;
    int   run_b      = 0;
    int   gaps_b     = 0;
    logic in_frame_b = 1'b0;

    always @(posedge clk) begin
        #2;
        if (!reset_n) begin
            idle_b     = 0;
            run_b      = 0;
            in_frame_b = 1'b0;
        end else begin
            if (mvalid_b) begin
                if (run_b == 0 && in_frame_b) begin
                    // GAP_CYCLES + 1 ready-setup cycle + 3 load cycles
                    check("gap3_idle_between_bursts", 64'(idle_b), 64'd7);
                    gaps_b++;
                end
                run_b++;
                idle_b     = 0;
                in_frame_b = 1'b1;
            end else begin
                if (run_b != 0) check("gap3_burst_len", 64'(run_b), 64'd3);
                run_b = 0;
                if (busy_b) idle_b++;
            end
            if (done_b) in_frame_b = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string name);
        check(name, {30'd0, s_ready_o, m_valid_o, m_data_o, m_sop_o, m_eop_o, m_sof_o,
                     m_eof_o, busy_o, frame_done_o, err_o, frame_cnt_o}, 64'd0);
    endtask

    // mode 0: upstream always valid; mode 1: valid toggles pseudo-randomly.
    // abort_at > 0: assert reset after that many accepted beats.
    // err_at >= 0: pulse start_i again when that many beats have been accepted.
    task automatic run_frame(input int mode, input int abort_at, input int err_at);
        int n;
        int d0;
        int b0;
        bit err_pulsed;
        n          = 0;
        err_pulsed = 0;
        d0         = done_seen;
        b0         = beats_seen;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == FRAME_BEATS || (abort_at > 0 && n == abort_at)) break;
            s_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = 8'(n);
            if (err_at >= 0 && n == err_at && !err_pulsed) begin
                start      = 1'b1;
                err_pulsed = 1;
            end
            if (s_valid && s_ready_o) begin
                exp_q.push_back(model(n));
                n++;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (abort_at > 0) begin
            check("abort_accept_count", 64'(n), 64'(abort_at));
            reset_n = 1'b0;
            @(negedge clk);
            check_reset_outputs("reset_midframe_outputs");
            exp_q.delete();
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
            return;
        end
        check("frame_accept_count", 64'(n), 64'(FRAME_BEATS));
        for (int i = 0; i < 200 && done_seen == d0; i++) @(negedge clk);
        check("frame_done_seen", 64'(done_seen - d0), 64'd1);
        repeat (4) @(negedge clk);
        check("frame_beats", 64'(beats_seen - b0), 64'(FRAME_BEATS));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("idle_after_frame", 64'(busy_o), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        start_b = 1'b0;
        valid_b = 1'b1;
        data_b  = 8'sd5;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset_n = 1'b1;
        @(negedge clk);

        // Frame with upstream always valid
        run_frame(0, 0, -1);
        check("frame_cnt_after_1", 64'(frame_cnt_o), STATS ? 64'd1 : 64'd0);
        check("err_clear_1", 64'(err_o), 64'd0);

        // Frame with stalling upstream
        run_frame(1, 0, -1);
        check("err_clear_2", 64'(err_o), 64'd0);

        // Second start mid-frame
        run_frame(0, 0, 10);
        check("err_set", 64'(err_o), 64'd1);
        repeat (20) @(negedge clk);
        check("err_sticky", 64'(err_o), 64'd1);

        // Reset after 20 accepted beats, then three full frames
        run_frame(0, 20, -1);
        run_frame(0, 0, -1);
        run_frame(1, 0, -1);
        run_frame(0, 0, -1);
        check("frame_cnt_after_3", 64'(frame_cnt_o), STATS ? 64'd3 : 64'd0);
        check("err_after_reset", 64'(err_o), 64'd0);

        // GAP_CYCLES=3 instance, upstream always valid
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 400 && !done_b; i++) @(negedge clk);
        check("gap3_frame_done", 64'(done_b), 64'd1);
        repeat (4) @(negedge clk);
        check("gap3_gap_count", 64'(gaps_b), 64'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
